// File: rtl/pipe_skid_stage_pkg.sv
// Shared encodings for the valid/ready inter-stage pipeline register.
// State values double as the occupancy a state represents.
package pipe_skid_stage_pkg;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam int   PIPE_CNT_W    = 2;

   typedef enum logic [PIPE_CNT_W-1:0] {
      PIPE_EMPTY = 2'b00,
      PIPE_ONE   = 2'b01,
      PIPE_FULL  = 2'b10
   } pipe_state_e;

endpackage

// File: rtl/pipe_skid_stage_entry.sv
// One storage slot (valid, write-enables, payload) with load and clear.
// Clear wins over load; payload is only zeroed on clear when ZERO_ON_CLEAR is set.
module pipe_entry
   import pipe_skid_stage_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int WE_W          = 4,
   parameter int ZERO_ON_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [WE_W-1:0]   load_we,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [WE_W-1:0]   we,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [WE_W-1:0]   we_q, we_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         we_d    = {WE_W{WRITE_DISABLE}};
         if (ZERO_ON_CLEAR != 0) begin
            data_d = '0;
         end
      end else if (load) begin
         valid_d = 1'b1;
         we_d    = load_we;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         valid_q <= 1'b0;
         we_q    <= {WE_W{WRITE_DISABLE}};
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign we    = we_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// in_ready is decoded from the skid register only, so no ready path runs through this stage.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int WE_W           = 4,
   parameter int ZERO_ON_BUBBLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WE_W-1:0]       in_we,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WE_W-1:0]       out_we,
   output logic [DATA_W-1:0]     out_data,
   output logic [PIPE_CNT_W-1:0] count
);

   pipe_state_e       state_q, state_d;
   logic              main_valid, skid_valid;
   logic [WE_W-1:0]   main_we, skid_we, main_we_in;
   logic [DATA_W-1:0] main_data, skid_data, main_data_in;
   logic              acc, dep;
   logic              main_load, main_clr, main_from_skid, skid_load, skid_clr;

   assign in_ready = ~skid_valid & ~rst;
   assign acc      = in_valid & in_ready;
   assign dep      = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= PIPE_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
         state_d  = PIPE_EMPTY;
      end else begin
         case (state_q)
            PIPE_EMPTY: begin
               if (acc) begin
                  main_load = 1'b1;
                  state_d   = PIPE_ONE;
               end
            end
            PIPE_ONE: begin
               if (acc && dep) begin
                  main_load = 1'b1;
               end else if (acc) begin
                  skid_load = 1'b1;
                  state_d   = PIPE_FULL;
               end else if (dep) begin
                  main_clr = 1'b1;
                  state_d  = PIPE_EMPTY;
               end
            end
            PIPE_FULL: begin
               // Oldest beat leaves first: the skid beat moves up into main.
               if (dep) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = PIPE_ONE;
               end
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
               state_d  = PIPE_EMPTY;
            end
         endcase
      end
   end

   assign main_we_in   = main_from_skid ? skid_we : in_we;
   assign main_data_in = main_from_skid ? skid_data : in_data;

   pipe_entry #(
      .DATA_W        (DATA_W),
      .WE_W          (WE_W),
      .ZERO_ON_CLEAR (ZERO_ON_BUBBLE)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clr),
      .load_we   (main_we_in),
      .load_data (main_data_in),
      .valid     (main_valid),
      .we        (main_we),
      .data      (main_data)
   );

   pipe_entry #(
      .DATA_W        (DATA_W),
      .WE_W          (WE_W),
      .ZERO_ON_CLEAR (ZERO_ON_BUBBLE)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .clear     (skid_clr),
      .load_we   (in_we),
      .load_data (in_data),
      .valid     (skid_valid),
      .we        (skid_we),
      .data      (skid_data)
   );

   assign out_valid = main_valid;
   assign out_we    = main_valid ? main_we : {WE_W{WRITE_DISABLE}};
   assign count     = PIPE_CNT_W'(main_valid) + PIPE_CNT_W'(skid_valid);

   generate
      if (ZERO_ON_BUBBLE != 0) begin : g_zero_bubble
         assign out_data = main_valid ? main_data : '0;
      end else begin : g_hold_bubble
         assign out_data = main_data;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed checks of pipe_skid_stage against a queue-based model.
// Two instances share stimulus: one zeroes data on bubbles, one holds it.
module tb_pipe_skid_stage;

   localparam int DW = 32;
   localparam int WW = 4;

   typedef struct packed {
      logic [WW-1:0] we;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [WW-1:0] in_we;
   logic [DW-1:0] in_data;

   logic          o_valid, o_ready, h_valid, h_ready;
   logic [WW-1:0] o_we, h_we;
   logic [DW-1:0] o_data, h_data;
   logic [1:0]    o_count, h_count;

   int vectors    = 0;
   int miscompares = 0;

   beat_t         q[$];
   logic [DW-1:0] last_main;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DW), .WE_W(WW), .ZERO_ON_BUBBLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(o_ready), .in_we(in_we), .in_data(in_data),
      .out_valid(o_valid), .out_ready(out_ready), .out_we(o_we), .out_data(o_data),
      .count(o_count)
   );

   pipe_skid_stage #(.DATA_W(DW), .WE_W(WW), .ZERO_ON_BUBBLE(0)) dut_hold (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(h_ready), .in_we(in_we), .in_data(in_data),
      .out_valid(h_valid), .out_ready(out_ready), .out_we(h_we), .out_data(h_data),
      .count(h_count)
   );

   // Model view: a FIFO of at most two beats; head is what is presented.
   function automatic logic [DW+WW+3:0] exp_zero();
      logic          v;
      logic [WW-1:0] w;
      logic [DW-1:0] d;
      v = (q.size() > 0);
      w = v ? q[0].we : '0;
      d = v ? q[0].data : '0;
      return {v, w, d, 2'(q.size()), (!rst && q.size() < 2)};
   endfunction

   function automatic logic [DW+WW+3:0] exp_hold();
      logic          v;
      logic [WW-1:0] w;
      v = (q.size() > 0);
      w = v ? q[0].we : '0;
      return {v, w, last_main, 2'(q.size()), (!rst && q.size() < 2)};
   endfunction

   task automatic tick();
      bit acc, dep;
      @(posedge clk);
      if (rst) begin
         q.delete();
         last_main = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         acc = in_valid && (q.size() < 2);
         dep = (q.size() > 0) && out_ready;
         if (dep) void'(q.pop_front());
         if (acc) q.push_back('{we: in_we, data: in_data});
      end
      if (q.size() > 0) last_main = q[0].data;
      #1;
   endtask

   task automatic drive(input logic v, input logic [WW-1:0] w, input logic [DW-1:0] d,
                        input logic r);
      in_valid  = v;
      in_we     = w;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic test_reset();
      logic [DW+WW+3:0] got, exp;
      rst = 1'b1; flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      q.delete(); last_main = '0;
      #1;
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_state got %h want %h", got, exp);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      vectors++;
      if (o_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready got %b want 1", o_ready);
      end
      // Store two beats, then hit rst between edges.
      drive(1'b1, 4'h3, 32'h1111, 1'b0); tick();
      drive(1'b1, 4'h5, 32'h2222, 1'b0); tick();
      vectors++;
      if (o_count !== 2'd2) begin
         miscompares++;
         $display("FAIL reset_prefill_count got %0d want 2", o_count);
      end
      #3 rst = 1'b1;
      q.delete(); last_main = '0;
      #1;
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp || h_data !== '0 || h_count !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_async got %h want %h hold_data %h", got, exp, h_data);
      end
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk) rst = 1'b0;
      tick();
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp || o_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_first_edge got %h want %h", got, exp);
      end
      $display("reset: mid-operation reset dropped stored beats, in_ready=%b", o_ready);
   endtask

   task automatic test_streaming();
      logic [DW+WW+3:0] got, exp;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 4'hF, DW'(i), 1'b1);
         tick();
         vectors++;
         got = {o_valid, o_we, o_data, o_count, o_ready};
         exp = exp_zero();
         if (got !== exp || o_data !== DW'(i) || o_count > 2'd1) begin
            miscompares++;
            $display("FAIL stream_beat%0d got %h want %h", i, got, exp);
         end
         $display("stream: beat %0d out_data=%h count=%0d", i, o_data, o_count);
      end
      drive(1'b0, '0, '0, 1'b1);
      tick();
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp) begin
         miscompares++;
         $display("FAIL stream_drain got %h want %h", got, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [DW+WW+3:0] got, exp;
      logic [DW-1:0]    want [3];
      want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
      drive(1'b1, 4'h1, 32'hA, 1'b0); tick();
      drive(1'b1, 4'h2, 32'hB, 1'b0); tick();
      drive(1'b1, 4'h4, 32'hC, 1'b0); tick();
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp || o_count !== 2'd2 || o_ready !== 1'b0 || o_data !== 32'hA) begin
         miscompares++;
         $display("FAIL bp_full got %h want %h", got, exp);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (o_valid !== 1'b1 || o_data !== want[k]) begin
            miscompares++;
            $display("FAIL bp_release%0d got v=%b d=%h want v=1 d=%h", k, o_valid, o_data, want[k]);
         end
         $display("backpressure: released %h", o_data);
         tick();
         if (k == 1) in_valid = 1'b0;
         vectors++;
         got = {o_valid, o_we, o_data, o_count, o_ready};
         exp = exp_zero();
         if (got !== exp) begin
            miscompares++;
            $display("FAIL bp_model%0d got %h want %h", k, got, exp);
         end
      end
   endtask

   task automatic test_flush();
      logic [DW+WW+3:0] got, exp;
      drive(1'b1, 4'h7, 32'h10, 1'b0); tick();
      drive(1'b1, 4'h8, 32'h20, 1'b0); tick();
      flush = 1'b1;
      drive(1'b1, 4'hF, 32'hD, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0, 1'b1);
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      if (got !== {1'b0, 4'h0, 32'h0, 2'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL flush_clear got %h want %h", got, {1'b0, 4'h0, 32'h0, 2'd0, 1'b1});
      end
      tick();
      vectors++;
      got = {o_valid, o_we, o_data, o_count, o_ready};
      exp = exp_zero();
      if (got !== exp || o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_no_credit got %h want %h", got, exp);
      end
      $display("flush: both entries discarded, count=%0d", o_count);
   endtask

   task automatic test_bubble();
      drive(1'b1, 4'h3, 32'h55, 1'b1); tick();
      drive(1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (o_valid !== 1'b0 || o_we !== 4'h0 || o_data !== 32'h0) begin
            miscompares++;
            $display("FAIL bubble_zero%0d got v=%b we=%h d=%h want 0/0/0", k, o_valid, o_we, o_data);
         end
         vectors++;
         if (h_we !== 4'h0 || h_data !== 32'h55) begin
            miscompares++;
            $display("FAIL bubble_hold%0d got we=%h d=%h want we=0 d=00000055", k, h_we, h_data);
         end
      end
      $display("bubble: zero instance d=%h, hold instance d=%h", o_data, h_data);
   endtask

   task automatic test_random();
      logic [DW+WW+3:0] got, exp;
      int               bad = 0;
      for (int c = 0; c < 10000; c++) begin
         flush = ($urandom_range(0, 99) == 0);
         drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
         tick();
         vectors++;
         got = {o_valid, o_we, o_data, o_count, o_ready};
         exp = exp_zero();
         if (got !== exp) begin
            miscompares++; bad++;
            if (bad < 10) $display("FAIL random_zero cyc %0d got %h want %h", c, got, exp);
         end
         vectors++;
         got = {h_valid, h_we, h_data, h_count, h_ready};
         exp = exp_hold();
         if (got !== exp) begin
            miscompares++; bad++;
            if (bad < 10) $display("FAIL random_hold cyc %0d got %h want %h", c, got, exp);
         end
         vectors++;
         if ((!o_valid && o_we !== '0) || (!h_valid && h_we !== '0)) begin
            miscompares++; bad++;
            if (bad < 10) $display("FAIL random_we_bubble cyc %0d got %h/%h want 0", c, o_we, h_we);
         end
      end
      flush = 1'b0;
      $display("random: 10000 cycles, %0d errors", bad);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_bubble();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (MEM/WB style).
- Carries an opaque payload plus a write-enable vector between two stages, using valid/ready handshaking instead of a global stall vector.
- A 2-entry skid buffer registers the backward ready path, so upstream ready never depends combinationally on downstream ready.
- Supports synchronous flush and guarantees that write-enables are never asserted on a bubble.

Parameters:
- DATA_W, 32, payload width in bits (wd/wdata/hi/lo/cp0 fields packed by the instantiating stage).
- WE_W, 4, write-enable vector width (wreg, whilo, cp0_we, LLbit_we, ...); forced to 0 on bubbles and flush.
- ZERO_ON_BUBBLE, 1, 1: out_data reads 0 whenever out_valid=0; 0: out_data holds its last value (saves muxes).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (exception/eret), active high.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat.
- in_we  in  WE_W  upstream write-enables.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts the beat.
- out_we  out  WE_W  write-enables of the presented beat, 0 when out_valid=0.
- out_data  out  DATA_W  payload of the presented beat.
- count  out  2  occupancy 0..2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding valid, we, data.
- States: EMPTY (count=0), ONE (main valid), FULL (main and skid valid). Encodings are 2'b00, 2'b01, 2'b10.
- Handshakes: acc = in_valid & in_ready; dep = out_valid & out_ready.
- in_ready = ~skid_valid, decoded from a register only. It is forced to 0 while rst=1.
- EMPTY:
  - acc -> ONE; main loads input.
- ONE:
  - acc & dep -> ONE; main loads input.
  - acc & ~dep -> FULL; skid loads input, main holds.
  - ~acc & dep -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready=0, so acc is impossible.
  - dep -> ONE; main loads skid, skid cleared.
  - Otherwise hold.
- Latency: 1 cycle from acc in EMPTY to out_valid. Sustained throughput is 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO. The skid beat is never overtaken.
- Data is captured only on acc. in_data and in_we are ignored when acc=0.
- out_valid = main_valid.
- out_we = main_we & {WE_W{main_valid}}. This invariant holds every cycle, including under reset and flush.
- With ZERO_ON_BUBBLE=1, out_data = main_data when main_valid, else 0.
- count = main_valid + skid_valid.
- flush has highest priority after rst:
  - Next edge clears both entries (valid=0, we=0, data=0 when ZERO_ON_BUBBLE) -> EMPTY.
  - A beat offered or departing in the flush cycle is discarded; no handshake is credited upstream.
  - in_ready is 1 in the following cycle.
- rst (async) clears every register immediately, independent of clk:
  - out_valid=0, out_we=0, out_data=0, count=0, state EMPTY.
  - Mid-operation reset drops all beats.
  - After deassertion, in_ready=1 from the first cycle.
- out_ready held 0 with in_valid=1: the stage fills to FULL in 2 cycles, then in_ready=0. No beat is lost or duplicated.
- out_ready toggled every cycle: no bubble beyond those implied by the handshake, and count never exceeds 2.
- Illegal state encoding 2'b11 -> EMPTY on next edge (defensive default).

Decomposition:
- Shared defines file (existing): RstEnable, WriteDisable, ZeroWord, plus new PipeEmpty/PipeOne/PipeFull state encodings and a PipeCntBus width define.
- One sub-module is natural: pipe_entry (valid/we/data register with load, clear and async reset), instantiated twice for main and skid.
- Field packing and unpacking stays in the instantiating stage, not in this block.

Test Plan:
- Reset: assert rst mid-clock with 2 beats stored -> outputs zero immediately (out_valid=0, out_we=0, count=0). After release, in_ready=1 on the first edge.
- Streaming: out_ready=1, push data 0x1..0x8 with we=4'hF back-to-back -> the same 8 beats appear in order, 1 cycle later each, count never above 1.
- Backpressure: push 0xA, 0xB, 0xC with out_ready=0 -> count=2, in_ready=0 after 2 beats, 0xC held upstream. Raising out_ready releases 0xA, 0xB, 0xC in order with no loss.
- Flush priority: count=2, then flush=1 with in_valid=1 (data 0xD) and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, out_we=0; 0xD and the departing beat are not credited.
- Bubble masking: in_valid=0 while in_we=4'hF and in_data=0xFFFF_FFFF -> out_we stays 0. With ZERO_ON_BUBBLE=1 out_data=0; with ZERO_ON_BUBBLE=0 out_data holds the last valid beat.
- Random: random in_valid/out_ready (50%) over 10k cycles with a scoreboard -> no drop, duplicate or reorder; out_we is never nonzero when out_valid=0.
